// File: rtl/lsm_regression_ctrl.sv
// ----------------------------------------------------------------------------
// lsm_regression_ctrl
//
// Purpose:
//   Sequencer for one Longstaff-Schwartz backward-induction step. It streams
//   in-the-money paths (x = underlying price, y = discounted continuation
//   cashflow) and accumulates the normal-equation sums for the basis
//   {1, x, x^2}. It then builds A (3x3) and B (3x1), pulses the solver start,
//   waits for done (bounded by TIMEOUT) and returns beta on a valid/ready
//   handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   sample handshake; in_x/in_y signed Q(FRAC); in_last
//                       marks the final sample of the batch
//   solve_start         one-cycle start pulse to the solver
//   solve_A / solve_B   row-major A and B, entry k at [k*WIDTH +: WIDTH]
//   solve_done          solver completion; solve_beta is its result
//   out_valid/out_ready beta handshake; out_beta latched beta
//   out_err             qualifies out_valid: too few samples or timeout
//   busy                high in any state other than IDLE
// ----------------------------------------------------------------------------
module lsm_regression_ctrl #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 16,
    parameter int GUARD   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x,
    input  logic signed [WIDTH-1:0] in_y,
    input  logic                    in_last,
    output logic                    solve_start,
    output logic [9*WIDTH-1:0]      solve_A,
    output logic [3*WIDTH-1:0]      solve_B,
    input  logic                    solve_done,
    input  logic [3*WIDTH-1:0]      solve_beta,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3*WIDTH-1:0]      out_beta,
    output logic                    out_err,
    output logic                    busy
);

    localparam int AW = WIDTH + GUARD;          // accumulator / product width
    localparam int MW = 2 * AW;                 // full multiply width
    localparam int CW = WIDTH - FRAC;           // sample counter width
    localparam int TW = $clog2(TIMEOUT + 1);    // timeout counter width

    localparam logic signed [AW-1:0] AMAX   = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] AMIN   = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [MW-1:0] AMAX_M = {{(AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [MW-1:0] AMIN_M = {{(AW+1){1'b1}}, {(AW-1){1'b0}}};
    localparam logic signed [AW-1:0] WMAX_A = {{(GUARD+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] WMIN_A = {{(GUARD+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]        CNT_MAX = {1'b0, {(CW-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_LAUNCH,
        S_WAIT,
        S_OUTPUT
    } state_t;

    // Fixed-point multiply: full-width product, arithmetic shift (floor),
    // then clamp into the accumulator width so huge powers never wrap.
    function automatic logic signed [AW-1:0] sat_mul(input logic signed [AW-1:0] a,
                                                     input logic signed [AW-1:0] b);
        logic signed [MW-1:0] ea;
        logic signed [MW-1:0] eb;
        logic signed [MW-1:0] p;
        ea = {{AW{a[AW-1]}}, a};
        eb = {{AW{b[AW-1]}}, b};
        p  = (ea * eb) >>> FRAC;
        if (p > AMAX_M)      return AMAX;
        else if (p < AMIN_M) return AMIN;
        else                 return p[AW-1:0];
    endfunction

    // Saturating accumulate: sums pin at the rails instead of wrapping.
    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                     input logic signed [AW-1:0] b);
        logic signed [AW:0] s;
        s = {a[AW-1], a} + {b[AW-1], b};
        if (s[AW] != s[AW-1]) return s[AW] ? AMIN : AMAX;
        return s[AW-1:0];
    endfunction

    // Clamp an accumulator value to a signed WIDTH-bit matrix entry.
    function automatic logic [WIDTH-1:0] sat_word(input logic signed [AW-1:0] v);
        if (v > WMAX_A)      return {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < WMIN_A) return {1'b1, {(WIDTH-1){1'b0}}};
        else                 return v[WIDTH-1:0];
    endfunction

    state_t               r_state;
    logic                 r_drain;
    logic [TW-1:0]        r_tmo;
    logic [CW-1:0]        r_count;

    logic                 r_vld_p1, r_vld_p2;
    logic signed [AW-1:0] r_x_p1, r_y_p1, r_x2_p1, r_xy_p1;
    logic signed [AW-1:0] r_x_p2, r_y_p2, r_x2_p2, r_xy_p2;
    logic signed [AW-1:0] r_x3_p2, r_x4_p2, r_x2y_p2;

    logic signed [AW-1:0] r_s1, r_s2, r_s3, r_s4, r_t0, r_t1, r_t2;

    logic                 r_solve_start;
    logic [9*WIDTH-1:0]   r_solve_A;
    logic [3*WIDTH-1:0]   r_solve_B;
    logic                 r_out_valid;
    logic [3*WIDTH-1:0]   r_out_beta;
    logic                 r_out_err;

    logic                 w_acc;
    logic                 w_clr;
    logic signed [AW-1:0] w_x_a, w_y_a, w_s0;
    logic signed [AW-1:0] w_s1_nxt, w_s2_nxt, w_s3_nxt, w_s4_nxt;
    logic signed [AW-1:0] w_t0_nxt, w_t1_nxt, w_t2_nxt;
    logic [WIDTH-1:0]     w_e0, w_e1, w_e2, w_e3, w_e4;

    assign in_ready    = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign busy        = (r_state != S_IDLE);
    assign solve_start = r_solve_start;
    assign solve_A     = r_solve_A;
    assign solve_B     = r_solve_B;
    assign out_valid   = r_out_valid;
    assign out_beta    = r_out_beta;
    assign out_err     = r_out_err;

    assign w_acc = in_valid && in_ready;
    // The first sample of a batch wipes the previous batch's sums.
    assign w_clr = w_acc && (r_state == S_IDLE);

    assign w_x_a = {{GUARD{in_x[WIDTH-1]}}, in_x};
    assign w_y_a = {{GUARD{in_y[WIDTH-1]}}, in_y};

    // Next-sum values are shared by the accumulators and the A/B build, so
    // the sample leaving stage 2 on the final DRAIN cycle is not missed.
    assign w_s1_nxt = r_vld_p2 ? sat_add(r_s1, r_x_p2)   : r_s1;
    assign w_s2_nxt = r_vld_p2 ? sat_add(r_s2, r_x2_p2)  : r_s2;
    assign w_s3_nxt = r_vld_p2 ? sat_add(r_s3, r_x3_p2)  : r_s3;
    assign w_s4_nxt = r_vld_p2 ? sat_add(r_s4, r_x4_p2)  : r_s4;
    assign w_t0_nxt = r_vld_p2 ? sat_add(r_t0, r_y_p2)   : r_t0;
    assign w_t1_nxt = r_vld_p2 ? sat_add(r_t1, r_xy_p2)  : r_t1;
    assign w_t2_nxt = r_vld_p2 ? sat_add(r_t2, r_x2y_p2) : r_t2;

    assign w_s0 = {{GUARD{1'b0}}, r_count, {FRAC{1'b0}}};
    assign w_e0 = sat_word(w_s0);
    assign w_e1 = sat_word(w_s1_nxt);
    assign w_e2 = sat_word(w_s2_nxt);
    assign w_e3 = sat_word(w_s3_nxt);
    assign w_e4 = sat_word(w_s4_nxt);

    // Stage 0 -> 1: x^2 and x*y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
            r_x_p1   <= '0;
            r_y_p1   <= '0;
            r_x2_p1  <= '0;
            r_xy_p1  <= '0;
        end else begin
            r_vld_p1 <= w_acc;
            if (w_acc) begin
                r_x_p1  <= w_x_a;
                r_y_p1  <= w_y_a;
                r_x2_p1 <= sat_mul(w_x_a, w_x_a);
                r_xy_p1 <= sat_mul(w_x_a, w_y_a);
            end
        end
    end

    // Stage 1 -> 2: x^3, x^4 and x^2*y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2 <= 1'b0;
            r_x_p2   <= '0;
            r_y_p2   <= '0;
            r_x2_p2  <= '0;
            r_xy_p2  <= '0;
            r_x3_p2  <= '0;
            r_x4_p2  <= '0;
            r_x2y_p2 <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_x_p2   <= r_x_p1;
                r_y_p2   <= r_y_p1;
                r_x2_p2  <= r_x2_p1;
                r_xy_p2  <= r_xy_p1;
                r_x3_p2  <= sat_mul(r_x2_p1, r_x_p1);
                r_x4_p2  <= sat_mul(r_x2_p1, r_x2_p1);
                r_x2y_p2 <= sat_mul(r_x2_p1, r_y_p1);
            end
        end
    end

    // Stage 2 -> sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_s4    <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            r_t2    <= '0;
        end else if (w_clr) begin
            r_count <= CW'(1);
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_s4    <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            r_t2    <= '0;
        end else begin
            if (w_acc && (r_count != CNT_MAX)) r_count <= r_count + CW'(1);
            r_s1 <= w_s1_nxt;
            r_s2 <= w_s2_nxt;
            r_s3 <= w_s3_nxt;
            r_s4 <= w_s4_nxt;
            r_t0 <= w_t0_nxt;
            r_t1 <= w_t1_nxt;
            r_t2 <= w_t2_nxt;
        end
    end

    // Control FSM with registered solver and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_drain       <= 1'b0;
            r_tmo         <= '0;
            r_solve_start <= 1'b0;
            r_solve_A     <= '0;
            r_solve_B     <= '0;
            r_out_valid   <= 1'b0;
            r_out_beta    <= '0;
            r_out_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_drain <= 1'b0;
                        r_state <= in_last ? S_DRAIN : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_acc && in_last) begin
                        r_drain <= 1'b0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Two cycles let the last sample clear both product stages.
                    if (!r_drain) begin
                        r_drain <= 1'b1;
                    end else if (r_count < CW'(3)) begin
                        r_out_beta  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end else begin
                        r_solve_A     <= {w_e4, w_e3, w_e2,
                                          w_e3, w_e2, w_e1,
                                          w_e2, w_e1, w_e0};
                        r_solve_B     <= {sat_word(w_t2_nxt), sat_word(w_t1_nxt),
                                          sat_word(w_t0_nxt)};
                        r_solve_start <= 1'b1;
                        r_state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_solve_start <= 1'b0;
                    // The launch cycle already counts as the first cycle waited.
                    r_tmo         <= TW'(1);
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (solve_done) begin
                        r_out_beta  <= solve_beta;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end else if (r_tmo >= TW'(TIMEOUT - 1)) begin
                        r_out_beta  <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsm_regression_ctrl.md
Name: lsm_regression_ctrl

Overview:
- Sequencer in front of the 3x3 regression solver (`solveRegression3x3`) for each Longstaff-Schwartz backward-induction step.
- Streams in-the-money paths (x = underlying price, y = discounted continuation cashflow) and accumulates the normal-equation sums for basis {1, x, x²}.
- Builds A (3x3) and B (3x1), pulses the solver's start, waits for done, and returns beta through a valid/ready handshake.

Parameters:
- WIDTH, 32, fixed-point word width (signed, two's complement)
- FRAC, 16, fractional bits (default Q16.16)
- GUARD, 8, extra accumulator bits above WIDTH
- TIMEOUT, 1023, max cycles to wait for solve_done before abort

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  path sample valid
- in_ready  out  1  controller accepts samples
- in_x  in  WIDTH  path price, signed QFRAC
- in_y  in  WIDTH  discounted cashflow, signed QFRAC
- in_last  in  1  marks final sample of the batch
- solve_start  out  1  one-cycle start pulse to solver
- solve_A  out  9*WIDTH  row-major A; entry k at [k*WIDTH +: WIDTH]
- solve_B  out  3*WIDTH  B; entry k at [k*WIDTH +: WIDTH]
- solve_done  in  1  solver completion
- solve_beta  in  3*WIDTH  solver result
- out_valid  out  1  beta available
- out_ready  in  1  consumer accepts beta
- out_beta  out  3*WIDTH  latched beta
- out_err  out  1  qualifies out_valid: 1 = count<3 or timeout, beta forced 0
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except in_ready=1; accumulators, count, pipeline 0.
- States: IDLE, ACCUM, DRAIN, LAUNCH, WAIT, OUTPUT.
- IDLE: in_ready=1. A handshake clears the accumulators and is accumulated as the first sample, then goes to ACCUM; if in_last is also set, goes to DRAIN.
- ACCUM: in_ready=1. Each handshake enters the pipeline. A handshake with in_last goes to DRAIN, and in_ready drops the next cycle.
- Product pipeline (2 stages):
  - Stage 1 registers x2 = (x*x)>>>FRAC and xy = (x*y)>>>FRAC.
  - Stage 2 registers x3 = (x2*x)>>>FRAC, x4 = (x2*x2)>>>FRAC, x2y = (x2*y)>>>FRAC.
  - Products use full-width intermediates; arithmetic shift, truncating toward −inf.
  - Accumulate at stage 2 output. A sample accepted at cycle t is in the sums at t+2.
- Accumulators:
  - Width WIDTH+GUARD, signed, wrap-free.
  - S0 = count<<FRAC; S1=Σx, S2=Σx2, S3=Σx3, S4=Σx4; T0=Σy, T1=Σxy, T2=Σx2y.
  - count saturates at 2^(WIDTH-FRAC-1)-1.
- DRAIN: waits 2 cycles for pipeline flush.
  - If count<3: out_beta=0, out_err=1, go to OUTPUT (no solver call).
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle):
  - solve_A = [S0 S1 S2; S1 S2 S3; S2 S3 S4]; solve_B = [T0 T1 T2].
  - Each entry is saturated to a signed WIDTH value.
  - solve_A/solve_B are registered here and held stable until the next batch starts.
  - solve_start=1 for exactly this cycle; go to WAIT and clear the timeout counter.
- WAIT:
  - On solve_done, latch solve_beta into out_beta, set out_err=0, go to OUTPUT.
  - If the counter reaches TIMEOUT first: out_beta=0, out_err=1, go to OUTPUT.
  - solve_done outside WAIT is ignored.
- OUTPUT:
  - out_valid=1, with out_beta/out_err stable until out_ready.
  - On handshake: out_valid falls the next cycle, go to IDLE.
- in_valid outside IDLE/ACCUM is not accepted (in_ready=0); upstream must hold.
- Reset mid-operation discards the batch; no solve_start or out_valid is generated afterwards.

Test Plan:
- Exact fit: x=1,2,3 with y=3,7,13, last on third → solve_start one pulse with:
  - solve_A = 0x30000,0x60000,0xE0000 / 0x60000,0xE0000,0x240000 / 0xE0000,0x240000,0x620000
  - solve_B = 0x170000,0x380000,0x940000
  - Solver model returns beta=0x10000×3 → out_valid with that beta, out_err=0.
- Underdetermined: two samples (x=1, x=2) with last → no solve_start; out_valid with beta=0, out_err=1.
- Timeout: TIMEOUT=15, solver model never asserts done → out_err=1 exactly 15 cycles after solve_start, beta=0.
- Backpressure:
  - in_valid gaps during ACCUM give sums identical to the gap-free run.
  - out_ready held low 20 cycles → out_valid and out_beta stable throughout.
  - Second batch has new sums, with no carry-over from the previous one.
- Async reset: deassert rst_n mid-WAIT → all outputs 0 immediately, in_ready=1. A late solve_done after reset is ignored and out_valid stays 0.
- Negative/saturation: x=−2.0 (0xFFFE0000) ×3, y=−1.0 → S1=−6.0 (0xFFFA0000), S3=−24.0, S4=48.0. Large x=100.0 ×3 → S4 entry saturates to 0x7FFFFFFF.
